// File: rtl/tisc_pkg.sv
// Shared constants and state encoding for the TISC MEM stage.
// Widths here are the default build; top-level parameters may override.
package tisc_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 8;
  localparam int REG_ADDR_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles without an ack; flags expiry at LIMIT.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // clear dominates so the count restarts on every BUSY entry
  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (inc && !expired)
      cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: ALU ops retire in 1 cycle, loads/stores run req/ack.
// Optional bus timeout abort under MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int DATA_W         = tisc_pkg::DATA_W,
  parameter int ADDR_W         = tisc_pkg::ADDR_W,
  parameter int REG_ADDR_W     = tisc_pkg::REG_ADDR_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ivalid,
  input  logic [REG_ADDR_W-1:0] ireg_write_addr,
  input  logic                  ireg_write_en,
  input  logic                  imem_to_reg,
  input  logic                  imem_write_en,
  input  logic [DATA_W-1:0]     ialu_out,
  input  logic [ADDR_W-1:0]     idata_read_addr,
  input  logic [ADDR_W-1:0]     idata_write_addr,
  input  logic [DATA_W-1:0]     idata_write_data,
  input  logic [ADDR_W-1:0]     inextPC,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  stall,
  output logic                  ovalid,
  output logic [REG_ADDR_W-1:0] oreg_write_addr,
  output logic                  oreg_write_en,
  output logic [DATA_W-1:0]     owb_data,
  output logic [ADDR_W-1:0]     onextPC,
  output logic                  oerr
);

  import tisc_pkg::*;

  mem_state_t state_q, state_d;

  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;

  logic                  ovalid_q, ovalid_d;
  logic [REG_ADDR_W-1:0] owa_q, owa_d;
  logic                  owe_q, owe_d;
  logic [DATA_W-1:0]     owb_q, owb_d;
  logic [ADDR_W-1:0]     opc_q, opc_d;
  logic                  oerr_q, oerr_d;

  logic mem_op;
  logic expired;
  logic stall_raw;
  logic req_raw;

  assign mem_op = ivalid & (imem_to_reg | imem_write_en);

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == IDLE),
    .inc     ((state_q == BUSY) && !dmem_ack),
    .expired (expired)
  );
`else
  wire unused_tmo = (TIMEOUT_CYCLES != 0);
  assign expired = 1'b0;
`endif

  // next-state, bus latch and retire logic
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    rd_en_d   = rd_en_q;
    pc_d      = pc_q;
    ovalid_d  = 1'b0;
    owa_d     = owa_q;
    owe_d     = owe_q;
    owb_d     = owb_q;
    opc_d     = opc_q;
    oerr_d    = 1'b0;
    stall_raw = 1'b0;
    req_raw   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall_raw = 1'b1;
          state_d   = BUSY;
          we_d      = imem_write_en;
          addr_d    = imem_write_en ? idata_write_addr
                                    : idata_read_addr;
          wdata_d   = imem_write_en ? idata_write_data
                                    : wdata_q;
          rd_d      = ireg_write_addr;
          rd_en_d   = ireg_write_en & ~imem_write_en;
          pc_d      = inextPC;
        end else if (ivalid) begin
          ovalid_d = 1'b1;
          owa_d    = ireg_write_addr;
          owe_d    = ireg_write_en;
          owb_d    = ialu_out;
          opc_d    = inextPC;
        end
      end
      BUSY: begin
        req_raw   = ~expired;
        stall_raw = ~dmem_ack & ~expired;
        if (dmem_ack) begin
          state_d  = IDLE;
          ovalid_d = 1'b1;
          owa_d    = rd_q;
          owe_d    = rd_en_q;
          owb_d    = we_q ? ialu_out : dmem_rdata;
          opc_d    = pc_q;
        end else if (expired) begin
          state_d  = IDLE;
          ovalid_d = 1'b1;
          oerr_d   = 1'b1;
          owa_d    = rd_q;
          owe_d    = 1'b0;
          opc_d    = pc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // all stage state; reset clears every field
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      rd_en_q  <= 1'b0;
      pc_q     <= '0;
      ovalid_q <= 1'b0;
      owa_q    <= '0;
      owe_q    <= 1'b0;
      owb_q    <= '0;
      opc_q    <= '0;
      oerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      rd_en_q  <= rd_en_d;
      pc_q     <= pc_d;
      ovalid_q <= ovalid_d;
      owa_q    <= owa_d;
      owe_q    <= owe_d;
      owb_q    <= owb_d;
      opc_q    <= opc_d;
      oerr_q   <= oerr_d;
    end
  end

  // stall is combinational from inputs, so gate it during reset
  assign stall           = stall_raw & rst_n;
  assign dmem_req        = req_raw;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_wdata      = wdata_q;
  assign ovalid          = ovalid_q;
  assign oreg_write_addr = owa_q;
  assign oreg_write_en   = owe_q;
  assign owb_data        = owb_q;
  assign onextPC         = opc_q;
  assign oerr            = oerr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a retire scoreboard.
// Define MEM_TIMEOUT_EN to also exercise the bus timeout abort.
module tb_mem_access_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ivalid;
  logic [3:0] ireg_write_addr;
  logic       ireg_write_en;
  logic       imem_to_reg;
  logic       imem_write_en;
  logic [7:0] ialu_out;
  logic [7:0] idata_read_addr;
  logic [7:0] idata_write_addr;
  logic [7:0] idata_write_data;
  logic [7:0] inextPC;
  logic       dmem_req;
  logic       dmem_we;
  logic [7:0] dmem_addr;
  logic [7:0] dmem_wdata;
  logic       dmem_ack;
  logic [7:0] dmem_rdata;
  logic       stall;
  logic       ovalid;
  logic [3:0] oreg_write_addr;
  logic       oreg_write_en;
  logic [7:0] owb_data;
  logic [7:0] onextPC;
  logic       oerr;

  mem_access_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ivalid           (ivalid),
    .ireg_write_addr  (ireg_write_addr),
    .ireg_write_en    (ireg_write_en),
    .imem_to_reg      (imem_to_reg),
    .imem_write_en    (imem_write_en),
    .ialu_out         (ialu_out),
    .idata_read_addr  (idata_read_addr),
    .idata_write_addr (idata_write_addr),
    .idata_write_data (idata_write_data),
    .inextPC          (inextPC),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_ack         (dmem_ack),
    .dmem_rdata       (dmem_rdata),
    .stall            (stall),
    .ovalid           (ovalid),
    .oreg_write_addr  (oreg_write_addr),
    .oreg_write_en    (oreg_write_en),
    .owb_data         (owb_data),
    .onextPC          (onextPC),
    .oerr             (oerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] wb;
    logic [3:0] ra;
    logic       we;
    logic [7:0] pc;
    logic       err;
    bit         chk_wb;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  int         cyc = 0;
  int         ack_at = 1;
  logic [7:0] rd_val = 8'h00;
  logic       stray_ack = 1'b0;
  int         busy_cnt = 0;

  int         req_cycles = 0;
  int         stall_cycles = 0;
  int         retires = 0;
  int         last_ret = 0;
  int         prev_ret = 0;
  logic       cap_we;
  logic [7:0] cap_addr;
  logic [7:0] cap_wdata;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // memory responder: ack in the ack_at-th request cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt   = 0;
      dmem_ack   = 1'b0;
      dmem_rdata = 8'h00;
    end else if (dmem_req) begin
      busy_cnt++;
      dmem_ack   = (busy_cnt == ack_at);
      dmem_rdata = rd_val;
    end else begin
      busy_cnt   = 0;
      dmem_ack   = stray_ack;
      dmem_rdata = rd_val;
    end
  end

  // monitor: bus stability, stall count, retire scoreboard
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (stall) stall_cycles++;
      if (dmem_req) begin
        if (req_cycles == 0) begin
          cap_we    = dmem_we;
          cap_addr  = dmem_addr;
          cap_wdata = dmem_wdata;
        end else begin
          check("bus_addr_stable", {24'h0, dmem_addr},
                {24'h0, cap_addr});
          check("bus_we_stable", {31'h0, dmem_we},
                {31'h0, cap_we});
        end
        req_cycles++;
      end
      if (ovalid) begin
        retires++;
        prev_ret = last_ret;
        last_ret = cyc;
        if (sb.size() == 0) begin
          check("unexpected_retire", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.chk_wb)
            check("owb_data", {24'h0, owb_data}, {24'h0, e.wb});
          check("oreg_write_addr", {28'h0, oreg_write_addr},
                {28'h0, e.ra});
          check("oreg_write_en", {31'h0, oreg_write_en},
                {31'h0, e.we});
          check("onextPC", {24'h0, onextPC}, {24'h0, e.pc});
          check("oerr", {31'h0, oerr}, {31'h0, e.err});
        end
      end
    end
  end

  task automatic clr();
    req_cycles   = 0;
    stall_cycles = 0;
    retires      = 0;
  endtask

  task automatic idle();
    ivalid        = 1'b0;
    imem_to_reg   = 1'b0;
    imem_write_en = 1'b0;
  endtask

  // present one op and hold it until the stage accepts it
  task automatic send(input logic [3:0] ra,
                      input logic       wen,
                      input logic       m2r,
                      input logic       mwe,
                      input logic [7:0] alu,
                      input logic [7:0] rda,
                      input logic [7:0] wra,
                      input logic [7:0] wd,
                      input logic [7:0] pc,
                      input logic       err);
    exp_t e;
    bit   done;
    e.ra     = ra;
    e.pc     = pc;
    e.err    = err;
    e.chk_wb = !err;
    e.we     = err ? 1'b0 : (wen & ~mwe);
    e.wb     = mwe ? alu : (m2r ? rd_val : alu);
    sb.push_back(e);
    ivalid           = 1'b1;
    ireg_write_addr  = ra;
    ireg_write_en    = wen;
    imem_to_reg      = m2r;
    imem_write_en    = mwe;
    ialu_out         = alu;
    idata_read_addr  = rda;
    idata_write_addr = wra;
    idata_write_data = wd;
    inextPC          = pc;
    done = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      #2;
      if (!stall) begin
        done = 1;
        break;
      end
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    idle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n            = 1'b0;
    ireg_write_addr  = '0;
    ireg_write_en    = 1'b0;
    ialu_out         = '0;
    idata_read_addr  = '0;
    idata_write_addr = '0;
    idata_write_data = '0;
    inextPC          = '0;
    idle();
    #12;
    check("rst_ovalid", {31'h0, ovalid}, 32'd0);
    check("rst_req", {31'h0, dmem_req}, 32'd0);
    check("rst_stall", {31'h0, stall}, 32'd0);
    check("rst_owb", {24'h0, owb_data}, 32'd0);
    check("rst_owe", {31'h0, oreg_write_en}, 32'd0);
    check("rst_oerr", {31'h0, oerr}, 32'd0);
    check("rst_addr", {24'h0, dmem_addr}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: ALU op, single-cycle retire, no stall
    clr();
    send(4'd5, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h00, 8'h00,
         8'h00, 8'h41, 1'b0);
    settle();
    check("t1_retires", retires, 32'd1);
    check("t1_stall", stall_cycles, 32'd0);
    check("t1_req", req_cycles, 32'd0);

    // 2: load, ack in third BUSY cycle
    clr();
    ack_at = 3;
    rd_val = 8'hA5;
    send(4'd7, 1'b1, 1'b1, 1'b0, 8'h99, 8'h20, 8'h55,
         8'h33, 8'h42, 1'b0);
    settle();
    check("t2_req_cycles", req_cycles, 32'd3);
    check("t2_stall_cycles", stall_cycles, 32'd3);
    check("t2_we", {31'h0, cap_we}, 32'd0);
    check("t2_addr", {24'h0, cap_addr}, 32'h20);
    check("t2_retires", retires, 32'd1);

    // 3: store, ack in first BUSY cycle
    clr();
    ack_at = 1;
    send(4'd3, 1'b1, 1'b0, 1'b1, 8'h66, 8'h44, 8'h10,
         8'h7E, 8'h43, 1'b0);
    settle();
    check("t3_req_cycles", req_cycles, 32'd1);
    check("t3_stall_cycles", stall_cycles, 32'd1);
    check("t3_we", {31'h0, cap_we}, 32'd1);
    check("t3_addr", {24'h0, cap_addr}, 32'h10);
    check("t3_wdata", {24'h0, cap_wdata}, 32'h7E);
    check("t3_retires", retires, 32'd1);

    // 3b: load and store both set, store wins
    clr();
    send(4'd9, 1'b1, 1'b1, 1'b1, 8'h5A, 8'h21, 8'h31,
         8'hC3, 8'h44, 1'b0);
    settle();
    check("t3b_we", {31'h0, cap_we}, 32'd1);
    check("t3b_addr", {24'h0, cap_addr}, 32'h31);
    check("t3b_wdata", {24'h0, cap_wdata}, 32'hC3);

    // 4: load then ALU back-to-back
    clr();
    rd_val = 8'hA5;
    send(4'd2, 1'b1, 1'b1, 1'b0, 8'h00, 8'h30, 8'h00,
         8'h00, 8'h45, 1'b0);
    send(4'd4, 1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 8'h00,
         8'h00, 8'h46, 1'b0);
    settle();
    check("t4_retires", retires, 32'd2);
    check("t4_no_bubble", last_ret - prev_ret, 32'd1);

    // 5: reset while BUSY, then stray ack
    clr();
    ack_at           = 1000;
    ivalid           = 1'b1;
    imem_to_reg      = 1'b1;
    imem_write_en    = 1'b0;
    idata_read_addr  = 8'h50;
    ireg_write_addr  = 4'd6;
    ireg_write_en    = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("t5_busy_req", {31'h0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_req", {31'h0, dmem_req}, 32'd0);
    check("t5_rst_stall", {31'h0, stall}, 32'd0);
    check("t5_rst_ovalid", {31'h0, ovalid}, 32'd0);
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr();
    stray_ack = 1'b1;
    rd_val    = 8'hEE;
    repeat (2) @(posedge clk);
    #1;
    stray_ack = 1'b0;
    settle();
    check("t5_stray_retires", retires, 32'd0);
    check("t5_stray_req", req_cycles, 32'd0);
    ack_at = 1;
    send(4'd8, 1'b1, 1'b0, 1'b0, 8'h77, 8'h00, 8'h00,
         8'h00, 8'h47, 1'b0);
    settle();
    check("t5_after_retires", retires, 32'd1);

`ifdef MEM_TIMEOUT_EN
    // 6: no ack, abort after the timeout
    clr();
    ack_at = 1000;
    send(4'd1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h60, 8'h00,
         8'h00, 8'h48, 1'b1);
    settle();
    check("t6_req_cycles", req_cycles, 32'd16);
    check("t6_retires", retires, 32'd1);
    check("t6_oerr_clear", {31'h0, oerr}, 32'd0);
    ack_at = 1;
`endif

    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
